// File: rtl/fpu_result_queue.sv
// fpu_result_queue: DEPTH-entry FIFO carrying FPU product words plus their
// error/overflow flags, with sticky exception status and a saturating
// overflow-event counter.
module fpu_result_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_error,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_error,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clear_sticky,
  output logic                     sticky_error,
  output logic                     sticky_overflow,
  output logic                     sticky_nan,
  output logic [7:0]               ovf_events
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  // Each entry is {result, error, overflow}, kept together so they stay aligned.
  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic push;
  logic pop;
  logic push_en;
  logic in_is_nan;

  // Handshake status derived from the registered occupancy only.
  always_comb begin
    in_ready  = (count < CNT_FULL);
    out_valid = (count != '0);
  end

  // Transfer qualifiers; reset suppresses both so a reset cycle changes nothing but the clear.
  always_comb begin
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    push_en   = push && !reset;
    in_is_nan = (in_result[30:23] == 8'hFF) && (in_result[22:0] != '0);
  end

  // Head entry presented to the consumer, forced to zero while the queue is empty.
  always_comb begin
    out_result   = '0;
    out_error    = 1'b0;
    out_overflow = 1'b0;
    if (out_valid) begin
      {out_result, out_error, out_overflow} = mem[rd_ptr];
    end
  end

  // Entry storage; not reset since occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= {in_result, in_error, in_overflow};
    end
  end

  // Circular-buffer pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky exception bits and saturating overflow counter; a push in the
  // clearing cycle is applied after the clear so its set survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_error    <= 1'b0;
      sticky_overflow <= 1'b0;
      sticky_nan      <= 1'b0;
      ovf_events      <= '0;
    end else begin
      if (clear_sticky) begin
        sticky_error    <= 1'b0;
        sticky_overflow <= 1'b0;
        sticky_nan      <= 1'b0;
        ovf_events      <= '0;
      end
      if (push) begin
        if (in_error) begin
          sticky_error <= 1'b1;
        end
        if (in_overflow) begin
          sticky_overflow <= 1'b1;
        end
        if (in_is_nan) begin
          sticky_nan <= 1'b1;
        end
        if (in_overflow) begin
          if (clear_sticky) begin
            ovf_events <= 8'd1;
          end else if (ovf_events != 8'hFF) begin
            ovf_events <= ovf_events + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed bench for fpu_result_queue (DEPTH=4).
module tb_fpu_result_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_error;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_error;
  logic        out_overflow;
  logic [2:0]  count;
  logic        clear_sticky;
  logic        sticky_error;
  logic        sticky_overflow;
  logic        sticky_nan;
  logic [7:0]  ovf_events;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fpu_result_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_error(in_error), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_error(out_error), .out_overflow(out_overflow),
    .count(count), .clear_sticky(clear_sticky),
    .sticky_error(sticky_error), .sticky_overflow(sticky_overflow),
    .sticky_nan(sticky_nan), .ovf_events(ovf_events)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns before checking/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic e, input logic o);
    in_valid    = v;
    in_result   = r;
    in_error    = e;
    in_overflow = o;
  endtask

  initial begin
    logic [3:0] k;
    reset = 1'b1; out_ready = 1'b0; clear_sticky = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_stickies", 32'({sticky_error, sticky_overflow, sticky_nan}), 32'd0);
    chk("rst_ovf_events", 32'(ovf_events), 32'd0);

    // Single pass with one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h40C00000, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_result", out_result, 32'h40C00000);
    chk("single_count", 32'(count), 32'd1);
    step();
    chk("single_count_after", 32'(count), 32'd0);
    chk("single_out_valid_after", 32'(out_valid), 32'd0);
    chk("single_out_result_after", out_result, 32'd0);

    // Fill to full, 5th push blocked (carries flags that must not leak into status)
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) drive(1'b1, 32'h7FC00005, 1'b1, 1'b1);
      else        drive(1'b1, 32'(i), 1'b0, 1'b0);
      chk($sformatf("fill_in_ready_%0d", i), 32'(in_ready), (i <= 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    chk("full_in_ready_with_out_ready", 32'(in_ready), 32'd0);
    chk("blocked_no_sticky", 32'({sticky_error, sticky_overflow, sticky_nan}), 32'd0);
    chk("blocked_no_ovf_event", 32'(ovf_events), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain_result_%0d", i), out_result, 32'(i));
      step();
    end
    chk("drain_count", 32'(count), 32'd0);

    // Wrap: hold occupancy at 2 with simultaneous push/pop
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 1'b0, 1'b0); step();
    drive(1'b1, 32'hA1, 1'b1, 1'b0); step();
    chk("wrap_pre_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      k = 4'(j + 2);
      drive(1'b1, 32'hA0 + 32'(k), k[0], k[1]);
      k = 4'(j);
      chk($sformatf("wrap_result_%0d", j), out_result, 32'hA0 + 32'(j));
      chk($sformatf("wrap_flags_%0d", j), 32'({out_error, out_overflow}), 32'({k[0], k[1]}));
      chk($sformatf("wrap_count_%0d", j), 32'(count), 32'd2);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("wrap_tail0", out_result, 32'hAA); step();
    chk("wrap_tail1", out_result, 32'hAB); step();
    chk("wrap_empty", 32'(count), 32'd0);

    // Status from the wrap traffic (ovf on k=2,3,6,7,10,11), then clear
    chk("wrap_sticky_error", 32'(sticky_error), 32'd1);
    chk("wrap_sticky_nan", 32'(sticky_nan), 32'd0);
    chk("wrap_ovf_events", 32'(ovf_events), 32'd6);
    clear_sticky = 1'b1; step(); clear_sticky = 1'b0;
    chk("clear_stickies", 32'({sticky_error, sticky_overflow, sticky_nan}), 32'd0);
    chk("clear_ovf_events", 32'(ovf_events), 32'd0);

    // Sticky: infinity is not NaN; quiet NaN is
    drive(1'b1, 32'h7F800000, 1'b1, 1'b1); step();
    chk("inf_not_nan", 32'(sticky_nan), 32'd0);
    drive(1'b1, 32'h7FC00000, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("sticky_ovf", 32'(sticky_overflow), 32'd1);
    chk("sticky_err", 32'(sticky_error), 32'd1);
    chk("sticky_nan", 32'(sticky_nan), 32'd1);
    chk("sticky_ovf_events", 32'(ovf_events), 32'd1);
    clear_sticky = 1'b1;
    drive(1'b1, 32'h3F800000, 1'b0, 1'b1); step();
    clear_sticky = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("clr_push_ovf_wins", 32'(sticky_overflow), 32'd1);
    chk("clr_push_ovf_events", 32'(ovf_events), 32'd1);
    chk("clr_push_nan_cleared", 32'(sticky_nan), 32'd0);
    chk("clr_push_err_cleared", 32'(sticky_error), 32'd0);
    step(); step();
    chk("sticky_drained", 32'(count), 32'd0);

    // Saturation: starts at 1, +1 per push
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 253) chk("sat_fe", 32'(ovf_events), 32'hFE);
      if (i == 254) chk("sat_ff", 32'(ovf_events), 32'hFF);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("sat_hold", 32'(ovf_events), 32'hFF);
    step(); step();
    chk("sat_drained", 32'(count), 32'd0);

    // Reset mid-operation with a push presented during reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b1);
      step();
    end
    chk("mid_count", 32'(count), 32'd3);
    reset = 1'b1;
    drive(1'b1, 32'hDEAD0000, 1'b1, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_result", out_result, 32'd0);
    chk("mid_rst_stickies", 32'({sticky_error, sticky_overflow, sticky_nan}), 32'd0);
    chk("mid_rst_ovf_events", 32'(ovf_events), 32'd0);
    drive(1'b1, 32'h12345678, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_result", out_result, 32'h12345678);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
